// File: rtl/cache_burst_ctrl_if.sv
// AHB-Lite master/slave signal bundle used by the cache line burst controller.
interface cache_burst_ctrl_if #(
  parameter int PA_BITS = 56,
  parameter int AHBW    = 64
);
  logic [PA_BITS-1:0] HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [2:0]         HBURST;
  logic [2:0]         HSIZE;
  logic [AHBW-1:0]    HWDATA;
  logic               HREADY;
  logic [AHBW-1:0]    HRDATA;

  modport master (
    output HADDR, HTRANS, HWRITE, HBURST, HSIZE, HWDATA,
    input  HREADY, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HBURST, HSIZE, HWDATA,
    output HREADY, HRDATA
  );
endinterface

// File: rtl/cache_burst_ctrl.sv
// Cache line fetch/writeback as a single incrementing AHB-Lite burst.
// IDLE issues NONSEQ, BURST streams SEQ beats and collects data, DONE holds the ack state under Stall.
module cache_burst_ctrl #(
  parameter  int PA_BITS = 56,
  parameter  int AHBW    = 64,
  parameter  int LINELEN = 512,
  localparam int BEATS   = LINELEN / AHBW,
  localparam int LOGBWPL = $clog2(BEATS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [AHBW-1:0]    CacheReadDataWord,
  output logic               CacheBusAck,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic               SelBusBeat,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               BusCommitted,
  cache_burst_ctrl_if.master bus
);

  localparam int OFS      = $clog2(AHBW / 8);
  localparam int LINE_OFS = $clog2(LINELEN / 8);
  localparam logic [LOGBWPL:0]   BEATS_C = (LOGBWPL + 1)'(BEATS);
  localparam logic [LOGBWPL-1:0] LAST    = LOGBWPL'(BEATS - 1);
  localparam logic [2:0] HBURST_C = (BEATS == 16) ? 3'b111 :
                                    (BEATS == 8)  ? 3'b101 :
                                    (BEATS == 4)  ? 3'b011 : 3'b001;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  state_t             state;
  logic [LOGBWPL:0]   adr_cnt;   // one extra bit so it can sit at BEATS once all addresses are out
  logic [LOGBWPL-1:0] data_cnt;
  logic               wr_q;
  logic               start;

  assign start       = (state == S_IDLE) && (CacheBusRW != 2'b00) && !Flush;
  assign bus.HBURST  = HBURST_C;
  assign bus.HSIZE   = 3'(OFS);

  // Bus outputs follow state and counters directly so they freeze whenever HREADY freezes the counters
  always_comb begin
    bus.HTRANS   = TR_IDLE;
    bus.HADDR    = CacheBusAdr;
    bus.HWRITE   = wr_q;
    BeatCount    = '0;
    SelBusBeat   = 1'b0;
    CacheBusAck  = 1'b0;
    BusCommitted = 1'b0;
    if (!reset) begin
      unique case (state)
        S_IDLE: begin
          bus.HWRITE = CacheBusRW[0];
          if (start) begin
            bus.HTRANS = TR_NONSEQ;
            SelBusBeat = CacheBusRW[0];
          end
        end
        S_BURST: begin
          bus.HTRANS   = (adr_cnt < BEATS_C) ? TR_SEQ : TR_IDLE;
          bus.HADDR    = {CacheBusAdr[PA_BITS-1:LINE_OFS], adr_cnt[LOGBWPL-1:0], {OFS{1'b0}}};
          BeatCount    = adr_cnt[LOGBWPL-1:0];
          SelBusBeat   = 1'b1;
          BusCommitted = 1'b1;
          CacheBusAck  = bus.HREADY && (data_cnt == LAST);
        end
        S_DONE: BusCommitted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      adr_cnt     <= '0;
      data_cnt    <= '0;
      wr_q        <= 1'b0;
      bus.HWDATA  <= '0;
      FetchBuffer <= '0;
    end else begin
      // Write data trails its address phase by one cycle
      if ((bus.HTRANS != TR_IDLE) && bus.HREADY && bus.HWRITE)
        bus.HWDATA <= CacheReadDataWord;
      unique case (state)
        S_IDLE: begin
          if (start && bus.HREADY) begin
            state    <= S_BURST;
            adr_cnt  <= (LOGBWPL + 1)'(1);
            data_cnt <= '0;
            wr_q     <= CacheBusRW[0];
          end
        end
        S_BURST: begin
          if (bus.HREADY) begin
            if (adr_cnt < BEATS_C) adr_cnt <= adr_cnt + 1'b1;
            data_cnt <= data_cnt + 1'b1;
            if (!wr_q) FetchBuffer[int'(data_cnt) * AHBW +: AHBW] <= bus.HRDATA;
            if (data_cnt == LAST) begin
              state    <= S_DONE;
              adr_cnt  <= '0;
              data_cnt <= '0;
            end
          end
        end
        S_DONE: begin
          if (!Stall) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_burst_ctrl.sv
// Scoreboard bench for cache_burst_ctrl: directed bursts push expectations, a negedge monitor checks them.
module tb_cache_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        Flush;
  logic [1:0]  CacheBusRW;
  logic [55:0] CacheBusAdr;
  logic [63:0] CacheReadDataWord;
  logic        CacheBusAck;
  logic [2:0]  BeatCount;
  logic        SelBusBeat;
  logic [511:0] FetchBuffer;
  logic        BusCommitted;
  logic        HREADY;
  logic [63:0] HRDATA;

  cache_burst_ctrl_if #(.PA_BITS(56), .AHBW(64)) bus ();

  assign bus.HREADY = HREADY;
  assign bus.HRDATA = HRDATA;
  // Cache model: word k of the line being written back is 0xA0+k
  assign CacheReadDataWord = 64'hA0 + 64'(BeatCount);

  cache_burst_ctrl #(.PA_BITS(56), .AHBW(64), .LINELEN(512)) dut (
    .clk               (clk),
    .reset             (reset),
    .Stall             (Stall),
    .Flush             (Flush),
    .CacheBusRW        (CacheBusRW),
    .CacheBusAdr       (CacheBusAdr),
    .CacheReadDataWord (CacheReadDataWord),
    .CacheBusAck       (CacheBusAck),
    .BeatCount         (BeatCount),
    .SelBusBeat        (SelBusBeat),
    .FetchBuffer       (FetchBuffer),
    .BusCommitted      (BusCommitted),
    .bus               (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [55:0] a;
    logic [1:0]  t;
    logic        w;
    logic [2:0]  bc;
    logic        sel;
    logic [2:0]  hb;
    logic [2:0]  hs;
  } arec_t;

  arec_t        addr_q[$];
  logic [63:0]  wdata_q[$];
  int           ack_q[$];
  logic [511:0] line_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  logic dp_wr = 1'b0;
  logic pend_line = 1'b0;
  logic cur_rd = 1'b0;

  always @(negedge clk) begin
    arec_t act;
    if (reset) begin
      dp_wr = 1'b0;
      pend_line = 1'b0;
    end else begin
      if (pend_line) begin
        pend_line = 1'b0;
        if (line_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fetch_line: got unexpected line check want none");
        end else chk("fetch_line", FetchBuffer, line_q.pop_front());
      end
      if (dp_wr && HREADY) begin
        dp_wr = 1'b0;
        if (wdata_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL hwdata: got %0h with no data phase expected", bus.HWDATA);
        end else chk("hwdata", bus.HWDATA, wdata_q.pop_front());
      end
      if (bus.HTRANS != 2'b00) begin
        act = '{a: bus.HADDR, t: bus.HTRANS, w: bus.HWRITE, bc: BeatCount,
                sel: SelBusBeat, hb: bus.HBURST, hs: bus.HSIZE};
        if (addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL addr_phase: got %0h want no address phase", act);
        end else begin
          chk("addr_phase", act, addr_q[0]);
          if (HREADY) begin
            void'(addr_q.pop_front());
            if (bus.HTRANS == 2'b10) cur_rd = !bus.HWRITE;
            if (bus.HWRITE) dp_wr = 1'b1;
          end
        end
      end
      if (CacheBusAck) begin
        if (ack_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ack: got ack at cycle %0d want none", cyc);
        end else chk("ack_cycle", cyc, ack_q.pop_front());
        pend_line = cur_rd;
      end
    end
  end

  // Stimulus
  task automatic run_burst(input logic [1:0] rw, input logic [55:0] adr, input logic [63:0] rd_base,
                           input int hold_at, input int hold_len, input int flush_at,
                           input int stall_len, input int rst_at);
    logic [511:0] line;
    int d, held, base, n_addr;
    logic wr;
    wr = rw[0];
    n_addr = (rst_at >= 0) ? rst_at + 1 : 8;
    for (int k = 0; k < n_addr; k++) begin
      arec_t r;
      r.a   = adr + 56'(k * 8);
      r.t   = (k == 0) ? 2'b10 : 2'b11;
      r.w   = wr;
      r.bc  = 3'(k);
      r.sel = (k == 0) ? wr : 1'b1;
      r.hb  = 3'b101;
      r.hs  = 3'd3;
      addr_q.push_back(r);
      if (wr) wdata_q.push_back(64'hA0 + 64'(k));
    end
    for (int k = 0; k < 8; k++) line[64*k +: 64] = rd_base + 64'(k);

    step();
    CacheBusRW = rw; CacheBusAdr = adr; HREADY = 1'b1; HRDATA = '0;
    base = cyc;
    if (rst_at < 0) begin
      ack_q.push_back(base + 8 + hold_len);
      if (!wr) line_q.push_back(line);
    end
    d = 0; held = 0;
    while (d < 8) begin
      step();
      if (d == rst_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0; CacheBusRW = 2'b00; Flush = 1'b0; HREADY = 1'b1;
        @(negedge clk);
        chk("rst_htrans", bus.HTRANS, 2'b00);
        chk("rst_beatcount", BeatCount, 3'd0);
        chk("rst_committed", BusCommitted, 1'b0);
        chk("rst_ack", CacheBusAck, 1'b0);
        chk("rst_fetchbuf", FetchBuffer, '0);
        return;
      end
      if (d == flush_at) Flush = 1'b1;
      if (d == hold_at && held < hold_len) begin
        HREADY = 1'b0; HRDATA = 64'hDEAD_BEEF_DEAD_BEEF; held++;
      end else begin
        HREADY = 1'b1; HRDATA = rd_base + 64'(d); d++;
      end
    end
    step();
    HREADY = 1'b1; Flush = 1'b0; HRDATA = '0;
    for (int s = 0; s < stall_len; s++) begin
      Stall = 1'b1;
      @(negedge clk);
      chk("done_committed", BusCommitted, 1'b1);
      chk("done_htrans", bus.HTRANS, 2'b00);
      step();
    end
    Stall = 1'b0; CacheBusRW = 2'b00;
    @(negedge clk);
    chk("done_last_committed", BusCommitted, 1'b1);
    step();
    @(negedge clk);
    chk("idle_committed", BusCommitted, 1'b0);
  endtask

  task automatic flush_idle();
    step();
    CacheBusRW = 2'b10; CacheBusAdr = 56'h9000; Flush = 1'b1; HREADY = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_idle_htrans", bus.HTRANS, 2'b00);
      step();
    end
    CacheBusRW = 2'b00; Flush = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; Stall = 1'b0; Flush = 1'b0; CacheBusRW = 2'b10;
    CacheBusAdr = 56'h1000; HREADY = 1'b1; HRDATA = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_htrans", bus.HTRANS, 2'b00);
    chk("reset_beatcount", BeatCount, 3'd0);
    chk("reset_ack", CacheBusAck, 1'b0);
    chk("reset_selbeat", SelBusBeat, 1'b0);
    chk("reset_committed", BusCommitted, 1'b0);
    chk("reset_hwdata", bus.HWDATA, 64'h0);
    chk("reset_fetchbuf", FetchBuffer, '0);
    chk("hburst", bus.HBURST, 3'b101);
    chk("hsize", bus.HSIZE, 3'd3);
    step();
    reset = 1'b0; CacheBusRW = 2'b00;

    run_burst(2'b10, 56'h1000, 64'h0,    -1, 0, -1, 0, -1);
    run_burst(2'b01, 56'h2000, 64'h0,    -1, 0, -1, 0, -1);
    run_burst(2'b11, 56'h3000, 64'h0,    -1, 0, -1, 0, -1);
    run_burst(2'b10, 56'h4000, 64'h3300,  3, 2, -1, 0, -1);
    flush_idle();
    run_burst(2'b10, 56'h5000, 64'h5500, -1, 0,  4, 0, -1);
    run_burst(2'b10, 56'h6000, 64'h6600, -1, 0, -1, 3, -1);
    run_burst(2'b10, 56'h7000, 64'h7700, -1, 0, -1, 0,  5);
    run_burst(2'b10, 56'hFF_FFFF_FFFF_FFC0, 64'h8800, -1, 0, -1, 0, -1);

    repeat (3) step();
    chk("addr_q_drained", addr_q.size(), 0);
    chk("wdata_q_drained", wdata_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("line_q_drained", line_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_burst_ctrl.md
CACHE_BURST_CTRL -- requirements
Module: cache_burst_ctrl

Interface
Parameters
REQ-001 SHALL have parameter PA_BITS, default 56, physical address width.
REQ-002 SHALL have parameter AHBW, default 64, bus data width in bits.
REQ-003 SHALL have parameter LINELEN, default 512, cache line width in bits; BEATS = LINELEN/AHBW, legal values 2, 4, 8 or 16; LOGBWPL = log2(BEATS).

Ports (name, direction, width, meaning)
REQ-004 SHALL have port clk, in, 1, the single clock.
REQ-005 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-006 SHALL have port Stall, in, 1, pipeline stall; holds the completion state.
REQ-007 SHALL have port Flush, in, 1, pipeline flush; suppresses a new burst.
REQ-008 SHALL have port CacheBusRW, in, 2, [1] line fetch, [0] line writeback.
REQ-009 SHALL have port CacheBusAdr, in, PA_BITS, line-aligned burst address.
REQ-010 SHALL have port CacheReadDataWord, in, AHBW, writeback word selected by BeatCount.
REQ-011 SHALL have port CacheBusAck, out, 1, burst complete.
REQ-012 SHALL have port BeatCount, out, LOGBWPL, address-phase beat index.
REQ-013 SHALL have port SelBusBeat, out, 1, cache word select uses BeatCount.
REQ-014 SHALL have port FetchBuffer, out, LINELEN, assembled fetched line.
REQ-015 SHALL have port BusCommitted, out, 1, burst in flight and not abortable.
REQ-016 SHALL have ports HADDR out PA_BITS, HTRANS out 2, HWRITE out 1, HBURST out 3, HSIZE out 3, HWDATA out AHBW, HREADY in 1, HRDATA in AHBW, all AHB-Lite master semantics.

Function
REQ-017 SHALL implement states IDLE, BURST, DONE.
REQ-018 In IDLE with CacheBusRW != 0 and Flush = 0, SHALL drive HTRANS = NONSEQ, HADDR = CacheBusAdr, HWRITE = CacheBusRW[0]; on HREADY, SHALL go to BURST with the address counter set to 1.
REQ-019 In IDLE with Flush = 1 or CacheBusRW = 0, SHALL drive HTRANS = IDLE and remain in IDLE.
REQ-020 If CacheBusRW = 2'b11, writeback SHALL take priority.
REQ-021 In BURST, SHALL drive HTRANS = SEQ while address counter < BEATS, else HTRANS = IDLE.
REQ-022 In BURST, HADDR SHALL be {CacheBusAdr line bits, address counter, zero byte offset}.
REQ-023 The address counter SHALL increment on each HREADY while < BEATS.
REQ-024 The data counter SHALL start at 0 and increment on each HREADY in BURST.
REQ-025 On a read, SHALL capture HRDATA into FetchBuffer[AHBW*(data counter) +: AHBW] on each HREADY in BURST; other slices SHALL hold.
REQ-026 On a write, HWDATA SHALL be a register loaded with CacheReadDataWord on every accepted address phase, so it presents beat k during data phase k.
REQ-027 BeatCount SHALL equal the address counter modulo BEATS; it SHALL be 0 in IDLE.
REQ-028 SelBusBeat SHALL be 1 in BURST, and in IDLE when a write burst is starting.
REQ-029 HBURST SHALL be 3'b011 for BEATS = 4, 3'b101 for 8, 3'b111 for 16, and 3'b001 for 2.
REQ-030 HSIZE SHALL be log2(AHBW/8).
REQ-031 CacheBusAck SHALL be 1 for exactly the cycle in which data counter = BEATS-1 and HREADY = 1; the FSM SHALL then enter DONE.
REQ-032 DONE SHALL hold while Stall = 1 and return to IDLE when Stall = 0; no new burst SHALL start from DONE.
REQ-033 BusCommitted SHALL be 1 in BURST and DONE.
REQ-034 Flush SHALL NOT abort a burst in BURST.
REQ-035 HREADY = 0 SHALL freeze both counters, HADDR, HTRANS and HWDATA.

Reset
REQ-036 Reset SHALL force IDLE and set both counters, BeatCount, CacheBusAck, SelBusBeat, BusCommitted and HWDATA to 0, and HTRANS to IDLE; FetchBuffer SHALL reset to 0.
REQ-037 Reset mid-burst SHALL take effect the next cycle regardless of HREADY.

Verification (AHBW = 64, LINELEN = 512, BEATS = 8)
REQ-038 Fetch, HREADY always 1, adr 0x1000, HRDATA = beat index -> HADDR 0x1000..0x1038 step 8, NONSEQ then 7 SEQ, HBURST = 101, Ack in cycle 9, FetchBuffer word k = k.
REQ-039 Writeback, cache word k = 0xA0+k -> HWDATA 0xA0..0xA7 in data phases 0..7, HWRITE = 1, BeatCount 0..7.
REQ-040 Fetch with HREADY low 2 cycles at beat 3 -> HADDR/BeatCount hold, no extra capture, Ack delayed 2 cycles.
REQ-041 Flush = 1 with CacheBusRW = 10 in IDLE -> HTRANS stays IDLE; Flush asserted at beat 4 -> burst completes, Ack issued.
REQ-042 Stall = 1 for 3 cycles after Ack -> DONE held, BusCommitted = 1, single Ack pulse, then IDLE.
REQ-043 Reset at beat 5 -> next cycle IDLE, HTRANS = 00, counters 0, no Ack.
